// File: rtl/bp_me_io_cmd_arbiter_pkg.sv
// Shared types and helpers for the IO command arbiter: requester-ID sizing and
// the two-state command FSM encoding.
package bp_me_io_cmd_arbiter_pkg;

    // ID width for the common two-requester configuration.
    localparam int REQ_ID_WIDTH_DEFAULT = 1;

    typedef enum logic {
        e_idle,
        e_locked
    } arbState_e;

    function automatic int reqIdWidth(input int numReq);
        return (numReq > 2) ? $clog2(numReq) : 1;
    endfunction

endpackage

// File: rtl/bp_me_io_id_fifo.sv
// Small 1r1w FIFO holding requester IDs of outstanding commands.
// Push and pop may happen together at any occupancy, including full.
module bp_me_io_id_fifo #(
    parameter int width_p = 1,
    parameter int els_p   = 2
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    input  logic               yumi_i,
    output logic [width_p-1:0] data_o,
    output logic               v_o
);

    localparam int PTR_W = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int CNT_W = $clog2(els_p + 1);

    logic [width_p-1:0] r_mem [els_p];
    logic [PTR_W-1:0]   r_wrPtr;
    logic [PTR_W-1:0]   r_rdPtr;
    logic [CNT_W-1:0]   r_count;
    logic               w_push;
    logic               w_pop;
    logic               w_full;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    assign v_o    = (r_count != '0);
    assign w_full = (r_count == CNT_W'(els_p));
    assign w_pop  = yumi_i & v_o;
    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign w_push = v_i & (~w_full | w_pop);
    assign data_o = r_mem[r_rdPtr];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wrPtr <= nextPtr(r_wrPtr);
            if (w_pop)  r_rdPtr <= nextPtr(r_rdPtr);
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wrPtr] <= data_i;
    end

endmodule

// File: rtl/bp_me_io_cmd_arbiter.sv
// Round-robin arbiter sharing one single-beat IO command/response channel among
// several requesters, with a global credit limit and in-order response routing.
module bp_me_io_cmd_arbiter
    import bp_me_io_cmd_arbiter_pkg::*;
#(
    parameter int num_req_p           = 2,
    parameter int max_credits_p       = 8,
    parameter int io_data_width_p     = 64,
    parameter int mem_header_width_lp = 64
) (
    input  logic                                     clk_i,
    input  logic                                     reset_n_i,
    input  logic [num_req_p*mem_header_width_lp-1:0] req_header_i,
    input  logic [num_req_p*io_data_width_p-1:0]     req_data_i,
    input  logic [num_req_p-1:0]                     req_v_i,
    output logic [num_req_p-1:0]                     req_yumi_o,
    output logic [mem_header_width_lp-1:0]           resp_header_o,
    output logic [io_data_width_p-1:0]               resp_data_o,
    output logic [num_req_p-1:0]                     resp_v_o,
    input  logic [num_req_p-1:0]                     resp_ready_and_i,
    output logic [mem_header_width_lp-1:0]           io_cmd_header_o,
    output logic [io_data_width_p-1:0]               io_cmd_data_o,
    output logic                                     io_cmd_v_o,
    input  logic                                     io_cmd_yumi_i,
    output logic                                     io_cmd_last_o,
    input  logic [mem_header_width_lp-1:0]           io_resp_header_i,
    input  logic [io_data_width_p-1:0]               io_resp_data_i,
    input  logic                                     io_resp_v_i,
    output logic                                     io_resp_ready_and_o,
    output logic                                     credits_empty_o,
    output logic                                     error_o
);

    localparam int ID_W   = reqIdWidth(num_req_p);
    localparam int CRED_W = $clog2(max_credits_p + 1);

    arbState_e             r_state;
    logic [ID_W-1:0]       r_grant;
    logic [ID_W-1:0]       r_rrPtr;
    logic [CRED_W-1:0]     r_credits;
    logic                  r_error;

    logic                  w_creditAvail;
    logic [2*num_req_p-1:0] w_rot;
    logic                  w_pickValid;
    logic [ID_W-1:0]       w_pick;
    logic [ID_W:0]         w_sum;
    logic                  w_cmdFire;
    logic                  w_respFire;
    logic [ID_W-1:0]       w_head;
    logic                  w_fifoV;

    logic [mem_header_width_lp-1:0] w_hdrArr [num_req_p];
    logic [io_data_width_p-1:0]     w_datArr [num_req_p];

    for (genvar g = 0; g < num_req_p; g++) begin : g_unpack
        assign w_hdrArr[g] = req_header_i[g*mem_header_width_lp +: mem_header_width_lp];
        assign w_datArr[g] = req_data_i[g*io_data_width_p +: io_data_width_p];
    end

    assign w_creditAvail = (r_credits < CRED_W'(max_credits_p));

    // Rotate valids so bit 0 is the RR pointer, then take the first set bit.
    always_comb begin
        w_rot       = {req_v_i, req_v_i} >> r_rrPtr;
        w_pickValid = 1'b0;
        w_pick      = '0;
        w_sum       = '0;
        for (int k = 0; k < num_req_p; k++) begin
            if (!w_pickValid && w_rot[k]) begin
                w_pickValid = 1'b1;
                w_sum       = {1'b0, r_rrPtr} + (ID_W+1)'(k);
                if (w_sum >= (ID_W+1)'(num_req_p)) w_sum = w_sum - (ID_W+1)'(num_req_p);
                w_pick      = w_sum[ID_W-1:0];
            end
        end
    end

    assign io_cmd_v_o      = (r_state == e_locked) & req_v_i[r_grant] & w_creditAvail;
    assign io_cmd_last_o   = io_cmd_v_o;
    assign io_cmd_header_o = w_hdrArr[r_grant];
    assign io_cmd_data_o   = w_datArr[r_grant];
    assign w_cmdFire       = io_cmd_v_o & io_cmd_yumi_i;

    always_comb begin
        req_yumi_o = '0;
        if (w_cmdFire) req_yumi_o[r_grant] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= e_idle;
            r_grant <= '0;
            r_rrPtr <= '0;
        end else begin
            unique case (r_state)
                e_idle: begin
                    if (w_pickValid && w_creditAvail) begin
                        r_grant <= w_pick;
                        r_state <= e_locked;
                    end
                end
                e_locked: begin
                    if (w_cmdFire) begin
                        r_rrPtr <= (r_grant == ID_W'(num_req_p - 1)) ? '0 : r_grant + 1'b1;
                        r_state <= e_idle;
                    end
                end
                default: r_state <= e_idle;
            endcase
        end
    end

    bp_me_io_id_fifo #(
        .width_p (ID_W),
        .els_p   (max_credits_p)
    ) idFifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .data_i    (r_grant),
        .v_i       (w_cmdFire),
        .yumi_i    (w_respFire),
        .data_o    (w_head),
        .v_o       (w_fifoV)
    );

    // Responses with no owner are drained rather than allowed to block the port.
    assign io_resp_ready_and_o = w_fifoV ? resp_ready_and_i[w_head] : 1'b1;
    assign w_respFire          = io_resp_v_i & io_resp_ready_and_o & w_fifoV;
    assign resp_header_o       = io_resp_header_i;
    assign resp_data_o         = io_resp_data_i;

    always_comb begin
        resp_v_o = '0;
        if (io_resp_v_i && w_fifoV) resp_v_o[w_head] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_credits <= '0;
            r_error   <= 1'b0;
        end else begin
            unique case ({w_cmdFire, w_respFire})
                2'b10:   r_credits <= r_credits + 1'b1;
                2'b01:   r_credits <= r_credits - 1'b1;
                default: r_credits <= r_credits;
            endcase
            if (io_resp_v_i && !w_fifoV) r_error <= 1'b1;
        end
    end

    assign credits_empty_o = (r_credits == '0);
    assign error_o         = r_error;

`ifndef SYNTHESIS
    a_yumiOneHot: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        io_cmd_yumi_i |-> $onehot(req_yumi_o));
    a_cmdVHeld: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (io_cmd_v_o && !io_cmd_yumi_i) |=> io_cmd_v_o);
`endif

endmodule

// File: tb/tb_bp_me_io_cmd_arbiter.sv
// Bench for the IO command arbiter: directed per-cycle vector table, hand-written
// error/reset sequence, and randomized traffic against a queue-based model.
module tb_bp_me_io_cmd_arbiter;

    localparam int N    = 2;
    localparam int MAXC = 2;
    localparam int HW   = 32;
    localparam int DW   = 32;

    logic            clk_i;
    logic            reset_n_i;
    logic [N*HW-1:0] req_header_i;
    logic [N*DW-1:0] req_data_i;
    logic [N-1:0]    req_v_i;
    logic [N-1:0]    req_yumi_o;
    logic [HW-1:0]   resp_header_o;
    logic [DW-1:0]   resp_data_o;
    logic [N-1:0]    resp_v_o;
    logic [N-1:0]    resp_ready_and_i;
    logic [HW-1:0]   io_cmd_header_o;
    logic [DW-1:0]   io_cmd_data_o;
    logic            io_cmd_v_o;
    logic            io_cmd_yumi_i;
    logic            io_cmd_last_o;
    logic [HW-1:0]   io_resp_header_i;
    logic [DW-1:0]   io_resp_data_i;
    logic            io_resp_v_i;
    logic            io_resp_ready_and_o;
    logic            credits_empty_o;
    logic            error_o;

    int checks = 0;
    int fails  = 0;

    logic [HW-1:0] reqHdr [N];
    logic [DW-1:0] reqDat [N];

    typedef struct {
        logic [1:0] reqV;
        logic       cmdYumi;
        logic       respV;
        logic [1:0] respReady;
        logic       expCmdV;
        int         expGnt;
        logic [1:0] expYumi;
        logic [1:0] expRespV;
        logic       expReady;
        logic       expEmpty;
    } vec_t;

    vec_t vecs[$];

    bp_me_io_cmd_arbiter #(
        .num_req_p           (N),
        .max_credits_p       (MAXC),
        .io_data_width_p     (DW),
        .mem_header_width_lp (HW)
    ) dut (
        .clk_i               (clk_i),
        .reset_n_i           (reset_n_i),
        .req_header_i        (req_header_i),
        .req_data_i          (req_data_i),
        .req_v_i             (req_v_i),
        .req_yumi_o          (req_yumi_o),
        .resp_header_o       (resp_header_o),
        .resp_data_o         (resp_data_o),
        .resp_v_o            (resp_v_o),
        .resp_ready_and_i    (resp_ready_and_i),
        .io_cmd_header_o     (io_cmd_header_o),
        .io_cmd_data_o       (io_cmd_data_o),
        .io_cmd_v_o          (io_cmd_v_o),
        .io_cmd_yumi_i       (io_cmd_yumi_i),
        .io_cmd_last_o       (io_cmd_last_o),
        .io_resp_header_i    (io_resp_header_i),
        .io_resp_data_i      (io_resp_data_i),
        .io_resp_v_i         (io_resp_v_i),
        .io_resp_ready_and_o (io_resp_ready_and_o),
        .credits_empty_o     (credits_empty_o),
        .error_o             (error_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic void addVec(input logic [1:0] rv, input logic y, input logic rsv,
                                   input logic [1:0] rdy, input logic ev, input int eg,
                                   input logic [1:0] ey, input logic [1:0] erv,
                                   input logic erdy, input logic eemp);
        vec_t v;
        v.reqV = rv; v.cmdYumi = y; v.respV = rsv; v.respReady = rdy;
        v.expCmdV = ev; v.expGnt = eg; v.expYumi = ey; v.expRespV = erv;
        v.expReady = erdy; v.expEmpty = eemp;
        vecs.push_back(v);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Drives one cycle's inputs shortly after the rising edge, then lets comb logic settle.
    task automatic applyStimulus(input logic [1:0] rv, input logic y, input logic rsv,
                                 input logic [1:0] rdy);
        req_v_i          = rv;
        io_cmd_yumi_i    = y;
        io_resp_v_i      = rsv;
        resp_ready_and_i = rdy;
        io_resp_header_i = $urandom;
        io_resp_data_i   = $urandom;
        req_header_i     = {reqHdr[1], reqHdr[0]};
        req_data_i       = {reqDat[1], reqDat[0]};
        #1;
    endtask

    task automatic nextCycle();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [8:0] ctrlBundle();
        return {io_cmd_v_o, io_cmd_last_o, req_yumi_o, resp_v_o,
                io_resp_ready_and_o, credits_empty_o, error_o};
    endfunction

    function automatic logic [1:0] oneHot(input int idx);
        return 2'b01 << idx;
    endfunction

    // Reference model state
    int   mQ[$];
    int   mGrant;
    int   mRr;
    bit   mErr;
    bit   hold [N];

    initial begin
        vec_t v;
        logic [1:0] rvRand;
        logic       yRand;
        logic       rsRand;
        logic [1:0] rdyRand;
        logic       expV;
        logic [1:0] expY;
        logic [1:0] expRv;
        logic       expRdy;
        int         h;
        bit         popNow;
        int         sizeBefore;

        reqHdr[0] = 32'h8000_0000; reqDat[0] = 32'hDEAD_BEEF;
        reqHdr[1] = 32'h4000_1000; reqDat[1] = 32'hCAFE_F00D;

        reset_n_i        = 1'b0;
        req_v_i          = '0;
        io_cmd_yumi_i    = 1'b0;
        io_resp_v_i      = 1'b0;
        resp_ready_and_i = '1;
        io_resp_header_i = '0;
        io_resp_data_i   = '0;
        req_header_i     = '0;
        req_data_i       = '0;

        #12;
        checkOutput("reset state", 64'(ctrlBundle()), 64'(9'b0_0_00_00_1_1_0));
        #11;
        reset_n_i = 1'b1;
        nextCycle();

        // Round-robin: both requesters always valid, downstream always accepts
        for (int k = 0; k < 8; k++) begin
            addVec(2'b11, 1'b0, (k > 0), 2'b11, 1'b0, 0, 2'b00,
                   (k > 0) ? oneHot((k - 1) % 2) : 2'b00, 1'b1, (k == 0));
            addVec(2'b11, 1'b1, 1'b0, 2'b11, 1'b1, k % 2, oneHot(k % 2), 2'b00, 1'b1, 1'b1);
        end
        addVec(2'b00, 1'b0, 1'b1, 2'b11, 1'b0, 0, 2'b00, 2'b10, 1'b1, 1'b0);

        // Single requester round trip
        addVec(2'b01, 1'b0, 1'b0, 2'b11, 1'b0, 0, 2'b00, 2'b00, 1'b1, 1'b1);
        addVec(2'b01, 1'b1, 1'b0, 2'b11, 1'b1, 0, 2'b01, 2'b00, 1'b1, 1'b1);
        addVec(2'b00, 1'b0, 1'b1, 2'b11, 1'b0, 0, 2'b00, 2'b01, 1'b1, 1'b0);
        addVec(2'b00, 1'b0, 1'b0, 2'b11, 1'b0, 0, 2'b00, 2'b00, 1'b1, 1'b1);

        // Credit stall, in-order routing, then back-pressure on requester 1
        addVec(2'b10, 1'b0, 1'b0, 2'b11, 1'b0, 0, 2'b00, 2'b00, 1'b1, 1'b1);
        addVec(2'b10, 1'b1, 1'b0, 2'b11, 1'b1, 1, 2'b10, 2'b00, 1'b1, 1'b1);
        addVec(2'b01, 1'b0, 1'b0, 2'b11, 1'b0, 0, 2'b00, 2'b00, 1'b1, 1'b0);
        addVec(2'b01, 1'b1, 1'b0, 2'b11, 1'b1, 0, 2'b01, 2'b00, 1'b1, 1'b0);
        addVec(2'b10, 1'b0, 1'b0, 2'b11, 1'b0, 0, 2'b00, 2'b00, 1'b1, 1'b0);
        addVec(2'b10, 1'b0, 1'b0, 2'b11, 1'b0, 0, 2'b00, 2'b00, 1'b1, 1'b0);
        addVec(2'b10, 1'b0, 1'b1, 2'b11, 1'b0, 0, 2'b00, 2'b10, 1'b1, 1'b0);
        addVec(2'b10, 1'b0, 1'b0, 2'b11, 1'b0, 0, 2'b00, 2'b00, 1'b1, 1'b0);
        addVec(2'b10, 1'b1, 1'b0, 2'b11, 1'b1, 1, 2'b10, 2'b00, 1'b1, 1'b0);
        addVec(2'b00, 1'b0, 1'b1, 2'b11, 1'b0, 0, 2'b00, 2'b01, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++)
            addVec(2'b00, 1'b0, 1'b1, 2'b01, 1'b0, 0, 2'b00, 2'b10, 1'b0, 1'b0);
        addVec(2'b00, 1'b0, 1'b1, 2'b11, 1'b0, 0, 2'b00, 2'b10, 1'b1, 1'b0);
        addVec(2'b00, 1'b0, 1'b0, 2'b11, 1'b0, 0, 2'b00, 2'b00, 1'b1, 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            applyStimulus(v.reqV, v.cmdYumi, v.respV, v.respReady);
            checkOutput($sformatf("vec%0d ctrl", i), 64'(ctrlBundle()),
                        64'({v.expCmdV, v.expCmdV, v.expYumi, v.expRespV,
                             v.expReady, v.expEmpty, 1'b0}));
            if (v.expCmdV) begin
                checkOutput($sformatf("vec%0d cmd header", i), 64'(io_cmd_header_o), 64'(reqHdr[v.expGnt]));
                checkOutput($sformatf("vec%0d cmd data", i), 64'(io_cmd_data_o), 64'(reqDat[v.expGnt]));
            end
            if (v.expRespV != 2'b00) begin
                checkOutput($sformatf("vec%0d resp header", i), 64'(resp_header_o), 64'(io_resp_header_i));
                checkOutput($sformatf("vec%0d resp data", i), 64'(resp_data_o), 64'(io_resp_data_i));
            end
            nextCycle();
        end

        // Spurious response with nothing outstanding
        applyStimulus(2'b00, 1'b0, 1'b1, 2'b11);
        checkOutput("spurious not forwarded", 64'({resp_v_o, io_resp_ready_and_o, error_o}), 64'(4'b00_1_0));
        nextCycle();
        applyStimulus(2'b00, 1'b0, 1'b0, 2'b11);
        checkOutput("spurious sets error", 64'(error_o), 64'(1));
        nextCycle();
        applyStimulus(2'b01, 1'b0, 1'b0, 2'b11);
        nextCycle();
        applyStimulus(2'b01, 1'b1, 1'b0, 2'b11);
        checkOutput("issue before reset", 64'({io_cmd_v_o, req_yumi_o, error_o}), 64'(4'b1_01_1));
        nextCycle();
        applyStimulus(2'b00, 1'b0, 1'b0, 2'b11);
        checkOutput("outstanding before reset", 64'(credits_empty_o), 64'(0));

        // Asynchronous reset mid-cycle with a command outstanding
        #2;
        reset_n_i = 1'b0;
        #1;
        req_v_i     = 2'b01;
        io_resp_v_i = 1'b1;
        #1;
        checkOutput("async reset outputs", 64'(ctrlBundle()), 64'(9'b0_0_00_00_1_1_0));
        req_v_i     = 2'b00;
        io_resp_v_i = 1'b0;
        #2;
        reset_n_i = 1'b1;
        nextCycle();
        applyStimulus(2'b00, 1'b0, 1'b1, 2'b11);
        checkOutput("late resp not forwarded", 64'({resp_v_o, io_resp_ready_and_o}), 64'(3'b00_1));
        nextCycle();
        applyStimulus(2'b00, 1'b0, 1'b0, 2'b11);
        checkOutput("late resp sets error", 64'(error_o), 64'(1));

        // Fresh reset, then randomized traffic against the queue model
        reset_n_i = 1'b0;
        #3;
        reset_n_i = 1'b1;
        nextCycle();
        mQ.delete();
        mGrant = -1;
        mRr    = 0;
        mErr   = 1'b0;
        for (int i = 0; i < N; i++) hold[i] = 1'b0;

        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!hold[i] && $urandom_range(2) == 0) begin
                    hold[i]   = 1'b1;
                    reqHdr[i] = $urandom;
                    reqDat[i] = $urandom;
                end
            end
            rvRand  = {hold[1], hold[0]};
            expV    = (mGrant >= 0) && hold[mGrant] && (mQ.size() < MAXC);
            yRand   = expV && ($urandom_range(1) == 1);
            rsRand  = (mQ.size() > 0) ? ($urandom_range(1) == 1) : ($urandom_range(15) == 0);
            rdyRand = 2'($urandom_range(3));
            applyStimulus(rvRand, yRand, rsRand, rdyRand);

            expY = yRand ? oneHot(mGrant) : 2'b00;
            if (mQ.size() > 0) begin
                h      = mQ[0];
                expRv  = rsRand ? oneHot(h) : 2'b00;
                expRdy = rdyRand[h];
            end else begin
                h      = 0;
                expRv  = 2'b00;
                expRdy = 1'b1;
            end
            checkOutput($sformatf("rand%0d ctrl", c), 64'(ctrlBundle()),
                        64'({expV, expV, expY, expRv, expRdy, (mQ.size() == 0), mErr}));
            if (expV) begin
                checkOutput($sformatf("rand%0d cmd header", c), 64'(io_cmd_header_o), 64'(reqHdr[mGrant]));
                checkOutput($sformatf("rand%0d cmd data", c), 64'(io_cmd_data_o), 64'(reqDat[mGrant]));
            end

            sizeBefore = mQ.size();
            popNow     = rsRand && expRdy && (sizeBefore > 0);
            if (rsRand && sizeBefore == 0) mErr = 1'b1;
            if (popNow) void'(mQ.pop_front());
            if (mGrant < 0) begin
                if (sizeBefore < MAXC) begin
                    for (int k = 0; k < N; k++) begin
                        if (mGrant < 0 && hold[(mRr + k) % N]) mGrant = (mRr + k) % N;
                    end
                end
            end else if (expV && yRand) begin
                mQ.push_back(mGrant);
                hold[mGrant] = 1'b0;
                mRr          = (mGrant + 1) % N;
                mGrant       = -1;
            end
            nextCycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/bp_me_io_cmd_arbiter.md
Name: bp_me_io_cmd_arbiter

Overview:
Shares one single-beat BedRock IO command/response channel among num_req_p requesters, for example the NBF loader and a debug or host requester.
- Round-robin arbitration on commands.
- Global credit limit on outstanding commands.
- Responses return in order and are routed back through a requester-ID FIFO.
- Sits between the requesters and the IO port of the tile/cfg bus.

Parameters:
bp_params_p, e_bp_default_cfg, processor config; supplies paddr/did/lce widths and io_noc_max_credits_p.
num_req_p, 2, number of requesters (>=2).
max_credits_p, io_noc_max_credits_p, maximum outstanding commands.
io_data_width_p, dword_width_gp, data width of every channel.
mem_header_width_lp, derived, BedRock mem header width.

Ports:
clk_i  in  1  clock.
reset_n_i  in  1  asynchronous, active-low reset.
req_header_i  in  num_req_p*mem_header_width_lp  per-requester command header.
req_data_i  in  num_req_p*io_data_width_p  per-requester command data.
req_v_i  in  num_req_p  per-requester command valid.
req_yumi_o  out  num_req_p  per-requester command accepted.
resp_header_o  out  mem_header_width_lp  response header, broadcast to all requesters.
resp_data_o  out  io_data_width_p  response data, broadcast.
resp_v_o  out  num_req_p  response valid, one-hot to the owning requester.
resp_ready_and_i  in  num_req_p  per-requester response ready.
io_cmd_header_o  out  mem_header_width_lp  downstream header.
io_cmd_data_o  out  io_data_width_p  downstream data.
io_cmd_v_o  out  1  downstream valid.
io_cmd_yumi_i  in  1  downstream accept.
io_cmd_last_o  out  1  equals io_cmd_v_o (single beat).
io_resp_header_i  in  mem_header_width_lp  upstream response header.
io_resp_data_i  in  io_data_width_p  upstream response data.
io_resp_v_i  in  1  upstream response valid.
io_resp_ready_and_o  out  1  upstream response ready.
credits_empty_o  out  1  no outstanding commands (used for fences).
error_o  out  1  sticky flag: unexpected response.

Behaviour:
- Reset: async assert on reset_n_i low. All state clears:
  - FSM = e_idle; RR pointer = 0; credit count = 0; ID FIFO empty; error_o = 0.
  - Outputs during reset: io_cmd_v_o = 0, req_yumi_o = 0, resp_v_o = 0, credits_empty_o = 1.
- Command FSM, two states:
  - e_idle: if any req_v_i and credits < max_credits_p, select the first valid requester at or after the RR pointer. Register that grant in grant_r and go to e_locked. io_cmd_v_o is 0 in e_idle, so grant latency is 1 cycle.
  - e_locked:
    - io_cmd_v_o = req_v_i[grant_r] & (credits < max_credits_p).
    - Header and data are muxed from grant_r.
    - req_yumi_o[grant_r] = io_cmd_yumi_i; all other yumi bits are 0.
    - On io_cmd_yumi_i: push grant_r to the ID FIFO, set RR pointer = grant_r+1 (wrapping at num_req_p), return to e_idle.
    - Once asserted, io_cmd_v_o must not drop until yumi. Requesters must hold valid, so the grant never switches mid-offer.
- Credits: counter of width clog2(max_credits_p+1).
  - +1 on io_cmd_yumi_i; -1 on the response handshake. Both in the same cycle leave it unchanged.
  - At max_credits_p, no new offers are made.
  - credits_empty_o = (count == 0).
- ID FIFO:
  - Depth max_credits_p, width clog2(num_req_p); it never overflows because of the credit limit.
  - Head h is valid when the FIFO is non-empty.
- Response routing:
  - resp_v_o[h] = io_resp_v_i & fifo_v; all other bits are 0.
  - io_resp_ready_and_o = fifo_v ? resp_ready_and_i[h] : 1.
  - Handshake (io_resp_v_i & io_resp_ready_and_o & fifo_v) pops the FIFO and decrements credits.
  - Header and data pass through combinationally.
  - A response arriving with the FIFO empty is drained (ready = 1), is not forwarded, and sets error_o until reset.
- Push and pop in the same cycle are legal at any FIFO occupancy.
- A command issued in the cycle a response retires for the same requester is legal.
- Reset while commands are outstanding: bookkeeping is lost. Any late responses set error_o; the parent must quiesce before resetting.
- Assertions (translate_off): exactly one requester yumi'd per io_cmd_yumi_i; io_cmd_v_o does not drop without yumi.

Decomposition:
- Shared package gets the requester-ID width constant and the arbiter FSM enum type.
- One natural sub-module: bp_me_io_id_fifo, a small 1r1w FIFO (may wrap bsg_fifo_1r1w_small).
- The arbiter and credit counter stay inline.

Test Plan:
- Single requester: req 0 issues uc_wr to 0x8000_0000 with data 0xDEAD_BEEF. Expect io_cmd_v_o the cycle after req_v_i; yumi; response routed to resp_v_o = 2'b01; credits return to 0.
- Round-robin fairness: both requesters hold valid continuously with downstream always yumi'ing. Expect grants to alternate 0, 1, 0, 1 over 8 commands.
- Credit stall: max_credits_p = 2, responses withheld. Expect two commands issued, third held (io_cmd_v_o = 0). Release one response and expect the third issues on the next arbitration.
- In-order routing: issue req1, req0, req1, then return three responses. Expect resp_v_o sequence 10, 01, 10, with header/data matching the upstream response.
- Back-pressure: resp_ready_and_i[1] = 0 for 5 cycles on a pending req1 response. Expect io_resp_ready_and_o = 0, no pop, credits held; pop on release.
- Spurious response and reset: io_resp_v_i with FIFO empty drives error_o = 1 with no resp_v_o. Asserting reset_n_i = 0 mid-stream asynchronously clears error_o and the credit count, and sets credits_empty_o = 1.
